// File: rtl/tt_vec_mul_wb.sv
// Writeback end of the vector multiply datapath: slices per-lane products into LO/HI/WIDE
// result beats, buffers them in a small FIFO and presents them on a valid/ready port.
module tt_vec_mul_wb #(
  parameter int VLEN  = 256,
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_mulen_0a,
  input  logic [1:0]               i_sew_0a,
  input  logic [1:0]               i_op_0a,
  input  logic [TAGW-1:0]          i_tag_0a,
  output logic                     o_mul_rdy_0a,
  input  logic [VLEN/8-1:0][128:0] i_sum_1a,
  output logic                     o_res_vld,
  input  logic                     i_res_rdy,
  output logic [VLEN-1:0]          o_res_data,
  output logic [TAGW-1:0]          o_res_tag,
  output logic                     o_res_beat,
  output logic                     o_res_last,
  output logic                     o_err
);

  localparam int NL = VLEN / 8;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] OP_HI   = 2'd1;
  localparam logic [1:0] OP_WIDE = 2'd2;

  logic            v1a;
  logic [1:0]      sew1a, op1a;
  logic [TAGW-1:0] tag1a;
  logic [CW-1:0]   count, push_n, infl;
  logic [CW:0]     used;
  logic [PW-1:0]   rd_ptr, wr_ptr, wr_ptr1;
  logic            wide_ok, bad_op, hi1a, pop, accept;
  logic [VLEN-1:0] nar, w0, w1;
  logic            unused_sum;

  logic [VLEN-1:0] mem_data [DEPTH];
  logic [TAGW-1:0] mem_tag  [DEPTH];
  logic            mem_beat [DEPTH];
  logic            mem_last [DEPTH];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_sum = ^i_sum_1a;
  assign hi1a    = (op1a == OP_HI);
  assign wide_ok = (op1a == OP_WIDE) && (sew1a != 2'd3);
  assign bad_op  = (op1a == 2'd3) || ((op1a == OP_WIDE) && (sew1a == 2'd3));
  assign push_n  = !v1a ? '0 : (wide_ok ? CW'(2) : CW'(1));
  // Credit reserves the nominal beat count of the in-flight op, even if it later degrades to LO.
  assign infl    = !v1a ? '0 : ((op1a == OP_WIDE) ? CW'(2) : CW'(1));
  assign used    = (CW+1)'(count) + (CW+1)'(infl);
  assign o_mul_rdy_0a = !i_reset && (used <= (CW+1)'(DEPTH - 2));
  assign accept  = i_mulen_0a && o_mul_rdy_0a;

  // Writeback handshake: a beat transfers on any cycle with o_res_vld & i_res_rdy; while
  // o_res_vld is high and i_res_rdy low, all o_res_* hold steady.
  assign o_res_vld  = (count != '0);
  assign pop        = o_res_vld && i_res_rdy;
  assign o_res_data = mem_data[rd_ptr];
  assign o_res_tag  = mem_tag[rd_ptr];
  assign o_res_beat = mem_beat[rd_ptr];
  assign o_res_last = mem_last[rd_ptr];
  assign wr_ptr1    = nxt(wr_ptr);

  always_comb begin
    nar = '0;
    w0  = '0;
    w1  = '0;
    case (sew1a)
      2'd0: begin
        for (int e = 0; e < NL; e++)
          nar[e*8 +: 8] = hi1a ? i_sum_1a[e][15:8] : i_sum_1a[e][7:0];
        for (int k = 0; k < NL/2; k++) begin
          w0[k*16 +: 16] = i_sum_1a[k][15:0];
          w1[k*16 +: 16] = i_sum_1a[k+NL/2][15:0];
        end
      end
      2'd1: begin
        for (int e = 0; e < NL/2; e++)
          nar[e*16 +: 16] = hi1a ? i_sum_1a[e][31:16] : i_sum_1a[e][15:0];
        for (int k = 0; k < NL/4; k++) begin
          w0[k*32 +: 32] = i_sum_1a[k][31:0];
          w1[k*32 +: 32] = i_sum_1a[k+NL/4][31:0];
        end
      end
      2'd2: begin
        for (int e = 0; e < NL/4; e++)
          nar[e*32 +: 32] = hi1a ? i_sum_1a[e][63:32] : i_sum_1a[e][31:0];
        for (int k = 0; k < NL/8; k++) begin
          w0[k*64 +: 64] = i_sum_1a[k][63:0];
          w1[k*64 +: 64] = i_sum_1a[k+NL/8][63:0];
        end
      end
      default: begin
        for (int e = 0; e < NL/8; e++)
          nar[e*64 +: 64] = hi1a ? i_sum_1a[e][127:64] : i_sum_1a[e][63:0];
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (v1a && !i_reset) begin
      mem_data[wr_ptr] <= wide_ok ? w0 : nar;
      mem_tag[wr_ptr]  <= tag1a;
      mem_beat[wr_ptr] <= 1'b0;
      mem_last[wr_ptr] <= !wide_ok;
      if (wide_ok) begin
        mem_data[wr_ptr1] <= w1;
        mem_tag[wr_ptr1]  <= tag1a;
        mem_beat[wr_ptr1] <= 1'b1;
        mem_last[wr_ptr1] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v1a    <= 1'b0;
      sew1a  <= '0;
      op1a   <= '0;
      tag1a  <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      o_err  <= 1'b0;
    end else begin
      v1a    <= accept;
      sew1a  <= i_sew_0a;
      op1a   <= i_op_0a;
      tag1a  <= i_tag_0a;
      count  <= count + push_n - CW'(pop);
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (push_n == CW'(2))      wr_ptr <= nxt(wr_ptr1);
      else if (push_n == CW'(1)) wr_ptr <= wr_ptr1;
      o_err  <= o_err | (i_mulen_0a & !o_mul_rdy_0a) | (v1a & bad_op);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) assert ((CW+1)'(count) + (CW+1)'(push_n) <= (CW+1)'(DEPTH));
  end

endmodule
